// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with byte-strobed register writes and a maskable
// interrupt request. Reads are combinational; all state changes on the rising clock edge.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic       hit;
  logic [1:0] sel;
  logic       en, im, auto_reload;
  // Byte offset within a register carries no meaning here.
  logic       unused_addr_lo;

  assign hit            = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel            = addr[3:2];
  assign unused_addr_lo = ^addr[1:0];

  assign en          = ctrl_q[0];
  assign im          = ctrl_q[3];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  // Next-state: FSM first, then bus writes so a CTRL write overrides the INT auto-disable.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      StIdle: begin
        if (en) begin
          state_d    = StLoad;
          irq_flag_d = 1'b0;
        end
      end
      StLoad: begin
        count_d = preset_q;
        state_d = en ? StCnt : StIdle;
      end
      StCnt: begin
        if (!en) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Saturate at zero; a preset of 0 expires like a preset of 1.
          count_d    = 32'd0;
          state_d    = StInt;
          irq_flag_d = 1'b1;
        end
      end
      StInt: begin
        state_d = StIdle;
        if (auto_reload) begin
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (we && hit) begin
      case (sel)
        2'd0: begin
          if (byteen[0]) ctrl_d = wdata[3:0];
        end
        2'd1: begin
          for (int i = 0; i < 4; i++) begin
            if (byteen[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Read mux: unmapped slot and out-of-window addresses read zero.
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (sel)
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = 32'd0;
      endcase
    end
  end

  // Interrupt request is the latched flag gated by the mask bit.
  always_comb begin
    irq = irq_flag_q & im;
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter with hand-computed expectations.
module tb_timer_counter;

  localparam logic [31:0] Base = 32'h0000_7F00;
  localparam logic [31:0] ACtrl = Base;
  localparam logic [31:0] APre  = Base + 32'h4;
  localparam logic [31:0] ACnt  = Base + 32'h8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  timer_counter #(.BASE_ADDR(Base)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One write occupies exactly one rising edge; returns just after that edge.
  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    addr   = a;
    byteen = be;
    wdata  = d;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we     = 1'b0;
    byteen = 4'd0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    reset  = 1'b1;
    we     = 1'b0;
    addr   = 32'd0;
    byteen = 4'd0;
    wdata  = 32'd0;
    tick(2);
    @(negedge clk);
    reset = 1'b0;
    tick(1);

    // Reset state
    rd("rst_ctrl", ACtrl, 32'd0);
    rd("rst_preset", APre, 32'd0);
    rd("rst_count", ACnt, 32'd0);
    chk_irq("rst_irq", 1'b0);

    // One-shot, PRESET=3, CTRL=EN|IM
    wr(APre, 4'hF, 32'd3);
    wr(ACtrl, 4'hF, 32'h9);
    rd("os_ctrl_w", ACtrl, 32'h9);
    tick(1);
    rd("os_cnt_idle", ACnt, 32'd0);
    chk_irq("os_irq_e1", 1'b0);
    tick(1);
    rd("os_cnt_3", ACnt, 32'd3);
    tick(1);
    rd("os_cnt_2", ACnt, 32'd2);
    tick(1);
    rd("os_cnt_1", ACnt, 32'd1);
    chk_irq("os_irq_e4", 1'b0);
    tick(1);
    rd("os_cnt_0", ACnt, 32'd0);
    chk_irq("os_irq_e5", 1'b1);
    tick(1);
    rd("os_ctrl_en_clr", ACtrl, 32'h8);
    chk_irq("os_irq_e6", 1'b1);
    tick(3);
    chk_irq("os_irq_hold", 1'b1);
    rd("os_cnt_hold", ACnt, 32'd0);

    // Auto-reload, PRESET=2, CTRL=EN|MODE01|IM: pulse every 5 edges
    wr(APre, 4'hF, 32'd2);
    wr(ACtrl, 4'hF, 32'hB);
    chk_irq("ar_irq_stale", 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk_irq($sformatf("ar_irq_%0d", k), (k == 4 || k == 9));
    end
    wr(ACtrl, 4'hF, 32'h0);
    tick(2);

    // PRESET=0 behaves as 1; CTRL write on the INT edge keeps EN
    wr(APre, 4'hF, 32'd0);
    wr(ACtrl, 4'hF, 32'h9);
    tick(2);
    rd("p0_cnt", ACnt, 32'd0);
    chk_irq("p0_irq_e2", 1'b0);
    tick(1);
    chk_irq("p0_irq_e3", 1'b1);
    wr(ACtrl, 4'hF, 32'h9);
    rd("p0_bus_wins", ACtrl, 32'h9);
    chk_irq("p0_irq_int", 1'b1);
    tick(1);
    chk_irq("p0_irq_clr", 1'b0);
    wr(ACtrl, 4'hF, 32'h0);
    tick(2);

    // Byte strobes and read-only COUNT
    wr(APre, 4'hF, 32'd0);
    wr(APre, 4'b0100, 32'hAABB_CCDD);
    rd("be_preset", APre, 32'h00BB_0000);
    wr(APre, 4'b0000, 32'h1234_5678);
    rd("be_none", APre, 32'h00BB_0000);
    wr(ACnt, 4'hF, 32'hFFFF_FFFF);
    rd("cnt_ro", ACnt, 32'd0);

    // Masked one-shot: flag set internally, visible once IM is set
    wr(APre, 4'hF, 32'd3);
    wr(ACtrl, 4'hF, 32'h1);
    tick(5);
    chk_irq("mask_irq_e5", 1'b0);
    tick(1);
    rd("mask_ctrl", ACtrl, 32'h0);
    chk_irq("mask_irq_e6", 1'b0);
    wr(ACtrl, 4'hF, 32'h8);
    chk_irq("mask_unmask", 1'b1);

    // Pause and resume via LOAD
    wr(APre, 4'hF, 32'd10);
    wr(ACtrl, 4'hF, 32'h1);
    tick(4);
    rd("pause_cnt8", ACnt, 32'd8);
    chk_irq("pause_flag_clr", 1'b0);
    wr(ACtrl, 4'hF, 32'h0);
    rd("pause_cnt7", ACnt, 32'd7);
    tick(3);
    rd("pause_frozen", ACnt, 32'd7);
    wr(ACtrl, 4'hF, 32'h1);
    tick(2);
    rd("resume_reload", ACnt, 32'd10);
    tick(1);
    rd("resume_dec", ACnt, 32'd9);
    wr(ACtrl, 4'hF, 32'h0);
    tick(2);

    // Decode: unmapped slot and out-of-window writes/reads
    wr(Base + 32'hC, 4'hF, 32'hFFFF_FFFF);
    wr(Base + 32'h10, 4'hF, 32'hFFFF_FFFF);
    rd("dec_ctrl", ACtrl, 32'h0);
    rd("dec_preset", APre, 32'd10);
    rd("dec_rd_c", Base + 32'hC, 32'd0);
    tick(1);
    rd("dec_rd_10", Base + 32'h10, 32'd0);
    rd("dec_rd_14", Base + 32'h14, 32'd0);
    rd("dec_lo_bits", Base + 32'h7, 32'd10);

    // Reset asserted mid-count aborts immediately
    wr(ACtrl, 4'hF, 32'h9);
    tick(4);
    rd("mid_cnt", ACnt, 32'd8);
    reset = 1'b1;
    #1;
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    rd("mid_rst_ctrl", ACtrl, 32'd0);
    rd("mid_rst_preset", APre, 32'd0);
    rd("mid_rst_count", ACnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(12);
    rd("post_rst_count", ACnt, 32'd0);
    chk_irq("post_rst_irq", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
